// File: rtl/core_if_pkg.sv
// rtl/core_if_pkg.sv - shared types and constants for the fetch-stage controller
package core_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } if_state_e;

    localparam logic [31:0] PC_START_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_INCR      = 32'd4;

endpackage

// File: rtl/core_if_ctrl_if.sv
// rtl/core_if_ctrl_if.sv - L1 instruction cache request/response bus
interface core_if_ctrl_if;

    logic        l1i_req_val_out;
    logic [31:0] l1i_req_addr_out;
    logic        l1i_req_ack_in;
    logic        l1i_resp_val_in;
    logic [31:0] l1i_resp_data_in;

    // Fetch controller side
    modport master (
        output l1i_req_val_out,
        output l1i_req_addr_out,
        input  l1i_req_ack_in,
        input  l1i_resp_val_in,
        input  l1i_resp_data_in
    );

    // Cache side
    modport slave (
        input  l1i_req_val_out,
        input  l1i_req_addr_out,
        output l1i_req_ack_in,
        output l1i_resp_val_in,
        output l1i_resp_data_in
    );

endinterface

// File: rtl/core_if_skid.sv
// rtl/core_if_skid.sv - one-entry skid buffer holding a fetched pc/instruction pair
module core_if_skid
    import core_if_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        val_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        val_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // Flush beats load beats drain; data fields only change on load
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            val_q   <= 1'b0;
            pc_q    <= '0;
            instr_q <= INSTR_NOP;
        end else if (flush_i) begin
            val_q   <= 1'b0;
        end else if (load_i) begin
            val_q   <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (drain_i) begin
            val_q   <= 1'b0;
        end
    end

    assign val_o   = val_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/core_if_ctrl.sv
// rtl/core_if_ctrl.sv - fetch sequencer owning the fetch PC and the IF/DEC register
module core_if_ctrl
    import core_if_pkg::*;
#(
    parameter logic [31:0] PC_START = PC_START_DEF
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           dec_stall_in,
    input  logic           redir_val_in,
    input  logic [31:0]    redir_addr_in,
    core_if_ctrl_if.master l1i,
    output logic           if_val_out,
    output logic [31:0]    if_pc_out,
    output logic [31:0]    if_instr_out,
    output logic           if_kill_out
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        if_val_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        kill_q;

    logic        skid_val;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        ifdec_free;
    logic        resp_in_wait;
    logic        load_resp;
    logic        load_skid;
    logic        drain_skid;
    logic [31:0] redir_pc;

    // Decode is able to take a new instruction this cycle
    assign ifdec_free   = !if_val_q || !dec_stall_in;
    assign resp_in_wait = (state_q == ST_WAIT) && l1i.l1i_resp_val_in;
    assign load_resp    = resp_in_wait && !redir_val_in && ifdec_free;
    assign load_skid    = resp_in_wait && !redir_val_in && !ifdec_free;
    assign drain_skid   = (state_q == ST_HOLD) && !redir_val_in && !dec_stall_in;
    assign redir_pc     = redir_addr_in & ~32'h0000_0003;

    core_if_skid u_skid (
        .clk     (clk),
        .n_rst   (n_rst),
        .load_i  (load_skid),
        .drain_i (drain_skid),
        .flush_i (redir_val_in),
        .pc_i    (req_pc_q),
        .instr_i (l1i.l1i_resp_data_in),
        .val_o   (skid_val),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    // Fetch FSM, fetch PC, IF/DEC register and kill flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_START;
            req_pc_q   <= '0;
            if_val_q   <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= INSTR_NOP;
            kill_q     <= 1'b0;
        end else begin
            kill_q <= redir_val_in;

            if (redir_val_in) begin
                if_val_q   <= 1'b0;
                if_instr_q <= INSTR_NOP;
            end else if (load_resp) begin
                if_val_q   <= 1'b1;
                if_pc_q    <= req_pc_q;
                if_instr_q <= l1i.l1i_resp_data_in;
            end else if (drain_skid && skid_val) begin
                if_val_q   <= 1'b1;
                if_pc_q    <= skid_pc;
                if_instr_q <= skid_instr;
            end else if (!dec_stall_in) begin
                if_val_q   <= 1'b0;
                if_instr_q <= INSTR_NOP;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!redir_val_in) state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (l1i.l1i_req_ack_in) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + PC_INCR;
                        // An accepted request still owes a response even if redirected
                        state_q  <= redir_val_in ? ST_DROP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l1i.l1i_resp_val_in) begin
                        state_q <= (redir_val_in || ifdec_free) ? ST_REQ : ST_HOLD;
                    end else if (redir_val_in) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (redir_val_in || !dec_stall_in) state_q <= ST_REQ;
                end
                ST_DROP: begin
                    // The stale response clears DROP even when a new redirect lands with it
                    if (l1i.l1i_resp_val_in) state_q <= ST_REQ;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Redirect target overrides any increment taken above
            if (redir_val_in) pc_q <= redir_pc;
        end
    end

    assign l1i.l1i_req_val_out  = (state_q == ST_REQ);
    assign l1i.l1i_req_addr_out = pc_q;

    assign if_val_out   = if_val_q;
    assign if_pc_out    = if_pc_q;
    assign if_instr_out = if_instr_q;
    assign if_kill_out  = kill_q;

endmodule
